bus_mux_pipe: RTL and testbench
===============================

Name: bus_mux_pipe

Overview:
Parametrised, registered successor to the datapath bus multiplexer. It selects one of NSRC WIDTH-bit sources onto the shared datapath bus using per-source out-enables, with fixed priority where the highest index wins. The bus value is registered with one-cycle latency. The block holds the last value when the bus is undriven, and detects, counts and flags multi-driver conflicts for the control unit and the testbench.

Parameters:
WIDTH, 32, bus data width in bits
NSRC, 24, number of bus sources (index 0..NSRC-1)
CNT_W, 8, width of the saturating conflict counter
SEL_W, $clog2(NSRC), width of the owner index (derived, not overridable)

Ports:
clock  input  1  system clock, rising edge
clear  input  1  asynchronous active-high reset
src_data  input  NSRC*WIDTH  packed source data; source i occupies bits [i*WIDTH +: WIDTH]
src_out  input  NSRC  per-source out-enable; src_out[i]=1 requests source i onto the bus
err_clr  input  1  synchronous clear of conflict_sticky and conflict_cnt
bus_out  output  WIDTH  registered bus value
bus_valid  output  1  bus_out was driven by a source in the previous cycle
bus_owner  output  SEL_W  index of the source captured into bus_out
conflict  output  1  one-cycle pulse: previous cycle had two or more enables
conflict_sticky  output  1  latched conflict flag
conflict_cnt  output  CNT_W  saturating count of conflict cycles

Behaviour:
- Clock and reset: single clock domain, `clock`. `clear` is asynchronous and active-high.
- Reset values: bus_out=0, bus_valid=0, bus_owner=0, conflict=0, conflict_sticky=0, conflict_cnt=0, FSM=IDLE.
- Selection (combinational, registered at the next rising edge):
  - winner = highest i with src_out[i]=1.
  - n_en = popcount(src_out).
- Latency: all outputs change exactly one clock after src_out/src_data are sampled. There is no combinational path from inputs to outputs.
- FSM states, with the state taken from the sampled n_en each cycle:
  - IDLE (n_en=0): bus_out holds its previous value; bus_valid=0; bus_owner holds; conflict=0.
  - DRIVE (n_en=1): bus_out=src_data[winner]; bus_valid=1; bus_owner=winner; conflict=0.
  - CONFLICT (n_en>=2): bus_out=src_data[winner]; bus_valid=1; bus_owner=winner; conflict=1; conflict_sticky=1; conflict_cnt increments.
  - Any state may transition to any state every cycle. The state register is visible only through the outputs; no extra port.
- Counter and sticky rules:
  - conflict_cnt saturates at 2^CNT_W-1 and never wraps.
  - err_clr=1 with no conflict this cycle: conflict_cnt=0 and conflict_sticky=0 next cycle.
  - err_clr=1 in the same cycle as a conflict: conflict_cnt=1 and conflict_sticky=1 (the new event wins over the clear).
- Reset mid-operation: `clear` asserted at any time forces all reset values immediately, regardless of the clock. The first sample after `clear` deasserts is treated normally.
- Enable width: src_out bits at index >= NSRC do not exist. NSRC must be >= 2; a static assertion checks this at elaboration.

Optional Feature:
BUS_PARITY_EN
- Defined: adds output `bus_parity` (1 bit). It is registered alongside bus_out and equals the even parity (XOR-reduce) of the value loaded into bus_out. It holds in IDLE and resets to 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package bus_pkg holds:
  - Default WIDTH (32) and NSRC (24).
  - Source index constants: SRC_R0..SRC_R15=0..15, SRC_PC=16, SRC_HI=17, SRC_LO=18, SRC_ZHI=19, SRC_ZLO=20, SRC_MDR=21, SRC_INPORT=22, SRC_C=23. Highest index wins, so the sign-extended constant (SRC_C) has top priority.
  - State enum bus_state_t {IDLE, DRIVE, CONFLICT}.
- One sub-module: bus_prio_enc, parametrised by NSRC.
  - Purely combinational.
  - Outputs winner index, any_en and multi_en (n_en>=2).
  - bus_mux_pipe instantiates it and owns all registers.

Test Plan:
- Reset: assert `clear` mid-cycle with src_out[5]=1 -> all outputs 0 immediately; after deassert, next edge bus_out=src_data[5], bus_owner=5, bus_valid=1.
- Single driver: src_out=1<<SRC_MDR, MDR data 0xDEADBEEF -> one edge later bus_out=0xDEADBEEF, bus_owner=21, bus_valid=1, conflict=0.
- Hold: after the previous case, src_out=0 for 3 cycles -> bus_out stays 0xDEADBEEF, bus_valid=0, bus_owner=21.
- Conflict priority: src_out[3] and src_out[SRC_C] both set, R3 data 0x11, C data 0x22 -> bus_out=0x22, bus_owner=23, conflict=1 for one cycle, conflict_sticky=1, conflict_cnt=1.
- Saturation and clear: with CNT_W=2, hold a conflict for 5 cycles -> conflict_cnt=3. Then err_clr=1 with a conflict present -> cnt=1, sticky=1. Then err_clr=1 with no conflict -> cnt=0, sticky=0.
- Parity (BUS_PARITY_EN defined): drive 0x00000007 -> bus_parity=1; drive 0x00000003 -> bus_parity=0.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared constants and types for the datapath bus mux.
// Source indices: higher index wins bus arbitration.
package bus_pkg;

  localparam int BUS_WIDTH = 32;
  localparam int BUS_NSRC  = 24;

  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_PC     = 16;
  localparam int SRC_HI     = 17;
  localparam int SRC_LO     = 18;
  localparam int SRC_ZHI    = 19;
  localparam int SRC_ZLO    = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_C      = 23;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CONFLICT
  } bus_state_t;

endpackage

// File: rtl/bus_prio_enc.sv
// bus_prio_enc: highest-index-wins encoder over bus out-enables.
// Also reports whether any, or more than one, enable is set.
module bus_prio_enc
  import bus_pkg::*;
#(
  parameter  int NSRC  = BUS_NSRC,
  localparam int SEL_W = $clog2(NSRC)
) (
  input  logic [NSRC-1:0]  req,
  output logic [SEL_W-1:0] winner,
  output logic             any_en,
  output logic             multi_en
);

  // Scan upward so the last hit is the highest index.
  always_comb begin
    winner   = '0;
    any_en   = 1'b0;
    multi_en = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (req[i]) begin
        if (any_en) multi_en = 1'b1;
        any_en = 1'b1;
        winner = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_mux_pipe.sv
// bus_mux_pipe: registered priority bus mux with conflict tracking.
// Optional macro BUS_PARITY_EN adds a registered bus_parity output.
module bus_mux_pipe
  import bus_pkg::*;
#(
  parameter  int WIDTH = BUS_WIDTH,
  parameter  int NSRC  = BUS_NSRC,
  parameter  int CNT_W = 8,
  localparam int SEL_W = $clog2(NSRC)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]   src_out,
  input  logic              err_clr,
  output logic [WIDTH-1:0]  bus_out,
  output logic              bus_valid,
  output logic [SEL_W-1:0]  bus_owner,
  output logic              conflict,
  output logic              conflict_sticky,
`ifdef BUS_PARITY_EN
  output logic              bus_parity,
`endif
  output logic [CNT_W-1:0]  conflict_cnt
);

  if (NSRC < 2) begin : g_nsrc_chk
    $error("bus_mux_pipe: NSRC must be >= 2");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [SEL_W-1:0] winner;
  logic             any_en;
  logic             multi_en;
  logic [WIDTH-1:0] sel_data;

  bus_state_t       state_d,  state_q;
  logic [WIDTH-1:0] bus_d,    bus_q;
  logic [SEL_W-1:0] owner_d,  owner_q;
  logic             sticky_d, sticky_q;
  logic [CNT_W-1:0] cnt_d,    cnt_q;
`ifdef BUS_PARITY_EN
  logic             par_d,    par_q;
`endif

  bus_prio_enc #(
    .NSRC(NSRC)
  ) u_enc (
    .req     (src_out),
    .winner  (winner),
    .any_en  (any_en),
    .multi_en(multi_en)
  );

  assign sel_data = src_data[winner*WIDTH +: WIDTH];

  // Next-state: classify this cycle's enables and update bus/flags.
  always_comb begin
    state_d  = IDLE;
    bus_d    = bus_q;
    owner_d  = owner_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    unique case (1'b1)
      multi_en: begin
        state_d  = CONFLICT;
        bus_d    = sel_data;
        owner_d  = winner;
        sticky_d = 1'b1;
        if (err_clr)
          cnt_d = CNT_W'(1);
        else if (cnt_q != CNT_MAX)
          cnt_d = cnt_q + 1'b1;
      end
      (any_en & ~multi_en): begin
        state_d = DRIVE;
        bus_d   = sel_data;
        owner_d = winner;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (err_clr && !multi_en) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end
  end

`ifdef BUS_PARITY_EN
  // Parity of the value about to be loaded; holds with the bus in IDLE.
  always_comb begin
    par_d = ^bus_d;
  end
`endif

  // State and output registers with asynchronous clear.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= IDLE;
      bus_q    <= '0;
      owner_q  <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
`ifdef BUS_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      bus_q    <= bus_d;
      owner_q  <= owner_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
`ifdef BUS_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign bus_out         = bus_q;
  assign bus_valid       = (state_q != IDLE);
  assign bus_owner       = owner_q;
  assign conflict        = (state_q == CONFLICT);
  assign conflict_sticky = sticky_q;
  assign conflict_cnt    = cnt_q;
`ifdef BUS_PARITY_EN
  assign bus_parity      = par_q;
`endif

endmodule

// File: tb/tb_bus_mux_pipe.sv
// tb_bus_mux_pipe: directed vectors plus corner sequences.
// Runs the DUT with CNT_W=2 to reach counter saturation quickly.
module tb_bus_mux_pipe;

  localparam int W  = 32;
  localparam int NS = 24;
  localparam int CW = 2;

  logic            clock;
  logic            clear;
  logic [NS*W-1:0] src_data;
  logic [NS-1:0]   src_out;
  logic            err_clr;
  logic [W-1:0]    bus_out;
  logic            bus_valid;
  logic [4:0]      bus_owner;
  logic            conflict;
  logic            conflict_sticky;
  logic [CW-1:0]   conflict_cnt;
`ifdef BUS_PARITY_EN
  logic            bus_parity;
`endif

  logic [W-1:0] slot [NS];

  int n_chk  = 0;
  int n_fail = 0;

  bus_mux_pipe #(
    .WIDTH(W),
    .NSRC (NS),
    .CNT_W(CW)
  ) dut (
    .clock          (clock),
    .clear          (clear),
    .src_data       (src_data),
    .src_out        (src_out),
    .err_clr        (err_clr),
    .bus_out        (bus_out),
    .bus_valid      (bus_valid),
    .bus_owner      (bus_owner),
    .conflict       (conflict),
    .conflict_sticky(conflict_sticky),
`ifdef BUS_PARITY_EN
    .bus_parity     (bus_parity),
`endif
    .conflict_cnt   (conflict_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Pack per-source words into the flat source bus.
  always_comb begin
    src_data = '0;
    for (int i = 0; i < NS; i++)
      src_data[i*W +: W] = slot[i];
  end

  typedef struct {
    logic [23:0] so;
    logic        ec;
    logic [31:0] bus;
    logic        v;
    logic [4:0]  own;
    logic        c;
    logic        s;
    logic [1:0]  cnt;
  } vec_t;

  vec_t tv [9];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string nm,
                         input logic [31:0] b,
                         input logic v,
                         input logic [4:0] o,
                         input logic c,
                         input logic s,
                         input logic [1:0] n);
    chk({nm, " bus_out"}, bus_out, b);
    chk({nm, " bus_valid"}, 32'(bus_valid), 32'(v));
    chk({nm, " bus_owner"}, 32'(bus_owner), 32'(o));
    chk({nm, " conflict"}, 32'(conflict), 32'(c));
    chk({nm, " sticky"}, 32'(conflict_sticky), 32'(s));
    chk({nm, " cnt"}, 32'(conflict_cnt), 32'(n));
  endtask

  initial begin
    tv[0] = '{24'h000001, 1'b0, 32'hC0DE0000, 1'b1, 5'd0,  1'b0, 1'b0, 2'd0};
    tv[1] = '{24'h800000, 1'b0, 32'hC0DE0017, 1'b1, 5'd23, 1'b0, 1'b0, 2'd0};
    tv[2] = '{24'h000000, 1'b0, 32'hC0DE0017, 1'b0, 5'd23, 1'b0, 1'b0, 2'd0};
    tv[3] = '{24'h000084, 1'b0, 32'hC0DE0007, 1'b1, 5'd7,  1'b1, 1'b1, 2'd1};
    tv[4] = '{24'h000400, 1'b0, 32'hC0DE000A, 1'b1, 5'd10, 1'b0, 1'b1, 2'd1};
    tv[5] = '{24'h000000, 1'b1, 32'hC0DE000A, 1'b0, 5'd10, 1'b0, 1'b0, 2'd0};
    tv[6] = '{24'hFFFFFF, 1'b0, 32'hC0DE0017, 1'b1, 5'd23, 1'b1, 1'b1, 2'd1};
    tv[7] = '{24'h410000, 1'b0, 32'hC0DE0016, 1'b1, 5'd22, 1'b1, 1'b1, 2'd2};
    tv[8] = '{24'h000002, 1'b0, 32'hC0DE0001, 1'b1, 5'd1,  1'b0, 1'b1, 2'd2};

    for (int i = 0; i < NS; i++)
      slot[i] = 32'hC0DE0000 | 32'(i);
    clear   = 1'b1;
    src_out = '0;
    err_clr = 1'b0;

    #2;
    chk_all("reset", 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0);
`ifdef BUS_PARITY_EN
    chk("reset parity", 32'(bus_parity), 32'h0);
`endif
    @(negedge clock);
    clear = 1'b0;

    for (int i = 0; i < 9; i++) begin
      src_out = tv[i].so;
      err_clr = tv[i].ec;
      step();
      chk_all($sformatf("vec%0d", i), tv[i].bus, tv[i].v,
              tv[i].own, tv[i].c, tv[i].s, tv[i].cnt);
    end
    err_clr = 1'b0;

    slot[21] = 32'hDEADBEEF;
    src_out  = 24'(1) << 21;
    step();
    chk_all("mdr", 32'hDEADBEEF, 1'b1, 5'd21, 1'b0, 1'b1, 2'd2);
    src_out = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all($sformatf("hold%0d", k), 32'hDEADBEEF, 1'b0,
              5'd21, 1'b0, 1'b1, 2'd2);
    end

    err_clr = 1'b1;
    step();
    chk_all("clr0", 32'hDEADBEEF, 1'b0, 5'd21, 1'b0, 1'b0, 2'd0);
    err_clr  = 1'b0;
    slot[3]  = 32'h11;
    slot[23] = 32'h22;
    src_out  = (24'(1) << 3) | (24'(1) << 23);
    step();
    chk_all("prio", 32'h22, 1'b1, 5'd23, 1'b1, 1'b1, 2'd1);
    src_out = '0;
    step();
    chk_all("pulse", 32'h22, 1'b0, 5'd23, 1'b0, 1'b1, 2'd1);

    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    src_out = (24'(1) << 4) | (24'(1) << 9);
    for (int k = 0; k < 5; k++) step();
    chk_all("sat", 32'hC0DE0009, 1'b1, 5'd9, 1'b1, 1'b1, 2'd3);
    err_clr = 1'b1;
    step();
    chk_all("clr_conf", 32'hC0DE0009, 1'b1, 5'd9, 1'b1, 1'b1, 2'd1);
    src_out = '0;
    step();
    chk_all("clr_idle", 32'hC0DE0009, 1'b0, 5'd9, 1'b0, 1'b0, 2'd0);
    err_clr = 1'b0;

    slot[5] = 32'h55AA55AA;
    src_out = 24'(1) << 5;
    step();
    chk_all("pre_rst", 32'h55AA55AA, 1'b1, 5'd5, 1'b0, 1'b0, 2'd0);
    src_out = (24'(1) << 5) | (24'(1) << 6);
    step();
    chk("pre_rst sticky", 32'(conflict_sticky), 32'h1);
    src_out = 24'(1) << 5;
    #3;
    clear = 1'b1;
    #1;
    chk_all("mid_rst", 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0);
    @(negedge clock);
    clear = 1'b0;
    step();
    chk_all("post_rst", 32'h55AA55AA, 1'b1, 5'd5, 1'b0, 1'b0, 2'd0);

`ifdef BUS_PARITY_EN
    slot[0] = 32'h7;
    src_out = 24'(1);
    step();
    chk("par7", 32'(bus_parity), 32'h1);
    slot[0] = 32'h3;
    step();
    chk("par3", 32'(bus_parity), 32'h0);
    slot[1] = 32'h1;
    src_out = 24'(2);
    step();
    chk("par1", 32'(bus_parity), 32'h1);
    src_out = '0;
    step();
    chk("par_hold", 32'(bus_parity), 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
